// File: rtl/cpu_pkg.sv
// cpu_pkg: core-wide widths and the write-back request record shared by
// the pipeline and the write-back path.
package cpu_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO that also exposes per-entry valid bits and
// destination fields so the owner can build a pending-register mask.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [DEPTH-1:0][RD_W-1:0]   rd_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             full, do_push, do_pop;

    // count never exceeds DEPTH (a power of two), so its MSB alone means full
    assign full    = count_q[AW];
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign valid_o = valid_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        valid_d  = (valid_q & ~(DEPTH'(do_pop) << rd_ptr_q)) | (DEPTH'(do_push) << wr_ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
        assign rd_o[i] = mem_q[i][WIDTH-1 -: RD_W];
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: sole owner of the register-file write port; merges fixed-timing
// pipeline write-backs with buffered long-latency results.
module wb_arbiter #(
    parameter int XLEN         = cpu_pkg::XLEN,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [cpu_pkg::REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic                       pipe_stall,
    input  logic                       async_valid,
    output logic                       async_ready,
    input  logic [cpu_pkg::REG_AW-1:0] async_rd,
    input  logic [XLEN-1:0]            async_data,
    output logic                       rf_we,
    output logic [cpu_pkg::REG_AW-1:0] rf_rd_addr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [31:0]                pending_mask
);
    import cpu_pkg::REG_AW;

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } req_t;

    req_t                         out_q, out_d, head, async_req;
    logic                         we_q, we_d;
    logic [7:0]                   starve_q, starve_d;
    logic                         fifo_empty, push, pop, alu_take;
    logic [CW-1:0]                fifo_count;
    logic [DEPTH-1:0]             fifo_valid;
    logic [DEPTH-1:0][REG_AW-1:0] fifo_rd;
    logic [31:0]                  mask;

    assign async_req   = {async_rd, async_data};
    assign async_ready = fifo_count != CW'(DEPTH);
    assign pipe_stall  = (starve_q == 8'(STARVE_LIMIT)) && alu_valid;
    assign alu_take    = alu_valid && alu_rd != '0 && !pipe_stall;
    // A stalled or idle pipeline always leaves the slot to the FIFO head
    assign pop         = !fifo_empty && !alu_take;
    assign push        = async_valid && async_ready && async_rd != '0;

    sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH),
        .RD_W  (REG_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (async_req),
        .data_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .valid_o (fifo_valid),
        .rd_o    (fifo_rd)
    );

    always_comb begin
        we_d     = alu_take || pop;
        out_d    = alu_take ? {alu_rd, alu_data} : pop ? head : out_q;
        starve_d = (pop || fifo_empty) ? '0 : starve_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            out_q    <= '0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            out_q    <= out_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (fifo_valid[i]) mask[fifo_rd[i]] = 1'b1;
        if (we_q) mask[out_q.rd] = 1'b1;
        mask[0] = 1'b0;
    end

    assign rf_we        = we_q;
    assign rf_rd_addr   = out_q.rd;
    assign rf_wdata     = out_q.data;
    assign pending_mask = mask;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench; expected writes are queued as stimulus is
// driven and matched against every rf_we cycle.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        async_valid = 1'b0;
    logic [4:0]  async_rd = '0;
    logic [31:0] async_data = '0;
    logic        pipe_stall, async_ready, rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wdata, pending_mask;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    wb_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .pipe_stall   (pipe_stall),
        .async_valid  (async_valid),
        .async_ready  (async_ready),
        .async_rd     (async_rd),
        .async_data   (async_data),
        .rf_we        (rf_we),
        .rf_rd_addr   (rf_rd_addr),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rf_we) begin
            if (sb.size() == 0) begin
                check("spurious_we", rf_we, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_rd", rf_rd_addr, e.rd);
                check("wb_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        int i, j;
        step();
        step();
        check("rst_we", rf_we, 0);
        check("rst_rd", rf_rd_addr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_ready", async_ready, 1);
        check("rst_stall", pipe_stall, 0);
        check("rst_mask", pending_mask, 0);
        rst_n = 1'b1;
        step();

        // single pipeline write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        sb.push_back({5'd5, 32'hDEADBEEF});
        step();
        alu_valid = 1'b0;
        check("t1_we", rf_we, 1);
        check("t1_mask", pending_mask, 32'h20);
        step();
        check("t1_mask_clr", pending_mask, 0);

        // single async result, pipeline idle
        async_valid = 1'b1; async_rd = 5'd7; async_data = 32'h1234;
        check("t2_ready", async_ready, 1);
        sb.push_back({5'd7, 32'h1234});
        step();
        async_valid = 1'b0;
        check("t2_we0", rf_we, 0);
        check("t2_mask0", pending_mask, 32'h80);
        step();
        check("t2_we1", rf_we, 1);
        check("t2_mask1", pending_mask, 32'h80);
        step();
        check("t2_we2", rf_we, 0);
        check("t2_mask2", pending_mask, 0);

        // fill FIFO under a busy pipeline until starvation forces a stall
        for (int k = 0; k < 9; k++) sb.push_back({5'(k + 1), 32'hA000_0000 + k});
        sb.push_back({5'd16, 32'hC000_0000});
        sb.push_back({5'd10, 32'hA000_0009});
        for (int k = 1; k < 5; k++) sb.push_back({5'(16 + k), 32'hC000_0000 + k});
        i = 0;
        j = 0;
        for (int k = 0; k <= 10; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'hA000_0000 + i;
            async_valid = j < 5; async_rd = 5'(16 + j); async_data = 32'hC000_0000 + j;
            #1;
            check("t3_stall", pipe_stall, k == 9);
            check("t3_ready", async_ready, (k < 4) || (k >= 10));
            if (k == 8) check("t3_mask", pending_mask, 32'h000F_0100);
            step();
            if (k != 9) i++;
            if (k < 4 || k == 10) j++;
        end
        alu_valid = 1'b0;
        async_valid = 1'b0;
        repeat (6) step();
        check("t3_mask_clr", pending_mask, 0);
        check("t3_drained", sb.size(), 0);

        // rd=0 offers are consumed without a write
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
        async_valid = 1'b1; async_rd = 5'd0; async_data = 32'h6666;
        check("t4_ready", async_ready, 1);
        step();
        alu_valid = 1'b0;
        async_valid = 1'b0;
        check("t4_we0", rf_we, 0);
        check("t4_mask0", pending_mask, 0);
        step();
        check("t4_we1", rf_we, 0);
        check("t4_mask1", pending_mask, 0);

        // reset with three queued entries and a write in the output stage
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(21 + k); alu_data = 32'hB000_0000 + k;
            async_valid = 1'b1; async_rd = 5'(24 + k); async_data = 32'hE000_0000 + k;
            check("t5_ready", async_ready, 1);
            if (k < 2) sb.push_back({alu_rd, alu_data});
            step();
        end
        alu_valid = 1'b0;
        async_valid = 1'b0;
        check("t5_we_pre", rf_we, 1);
        check("t5_mask_pre", pending_mask, 32'h0780_0000);
        rst_n = 1'b0;
        #1;
        check("t5_rst_we", rf_we, 0);
        check("t5_rst_rd", rf_rd_addr, 0);
        check("t5_rst_wdata", rf_wdata, 0);
        check("t5_rst_mask", pending_mask, 0);
        check("t5_rst_ready", async_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check("t5_no_we", rf_we, 0);
        check("t5_mask", pending_mask, 0);

        // back-to-back async stream wrapping the pointers several times
        for (int k = 0; k < 20; k++) begin
            async_valid = 1'b1; async_rd = 5'(1 + k); async_data = $urandom;
            check("t6_ready", async_ready, 1);
            sb.push_back({async_rd, async_data});
            step();
        end
        async_valid = 1'b0;
        repeat (4) step();
        check("t6_drained", sb.size(), 0);
        check("t6_mask", pending_mask, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the single write port of the integer register file. Merges in-order pipeline write-backs (fixed timing, highest priority) with out-of-order results from long-latency units (loads, divider) buffered in a small FIFO. Drives registered `rf_we/rf_rd_addr/rf_wdata`. Publishes a pending-destination mask for the hazard unit.

## Interface
- `XLEN`, 32: data width.
- `DEPTH`, 4: async-result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 8: cycles a non-empty FIFO may wait before forcing a pipeline stall; 1..255.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  pipeline write-back request this cycle.
- `alu_rd`  in  5  pipeline destination register.
- `alu_data`  in  XLEN  pipeline result.
- `pipe_stall`  out  1  pipeline write-back not consumed this cycle; pipeline holds it.
- `async_valid`  in  1  long-latency result offered.
- `async_ready`  out  1  FIFO can accept (`count != DEPTH`).
- `async_rd`  in  5  destination of offered result.
- `async_data`  in  XLEN  offered result.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_rd_addr`  out  5  register-file write address (registered).
- `rf_wdata`  out  XLEN  register-file write data (registered).
- `pending_mask`  out  32  bit r set while a write to xr is queued or in the output stage.

## Operation
- Enqueue on `async_valid && async_ready`. Entries with `async_rd == 0` are accepted and discarded, never stored.
- Source select, each cycle:
  - `pipe_stall=1`: FIFO head wins.
  - else `alu_valid && alu_rd != 0`: pipeline wins.
  - else FIFO head if non-empty.
  - else nothing.
- `alu_valid` with `alu_rd == 0` is consumed, no write.
- Selected entry is latched into the output stage: `rf_we=1` with its rd/data the next cycle, otherwise `rf_we=0`.
- Starvation counter (8 bits):
  - Clears on dequeue or when the FIFO is empty.
  - Increments each cycle the FIFO is non-empty and not dequeued.
  - `pipe_stall = (counter == STARVE_LIMIT) && alu_valid`. When `alu_valid=0` the head drains normally and the counter clears.
- Simultaneous enqueue and dequeue: allowed when not full; count unchanged. When full, `async_ready=0` regardless of a same-cycle dequeue.
- `pending_mask`:
  - OR of one-hot(rd) over valid FIFO entries.
  - OR one-hot(`rf_rd_addr`) when `rf_we=1`.
  - Bit 0 is always 0.
- WAW ordering between sources is not resolved here. The hazard unit must not issue a pipeline write to r while `pending_mask[r]=1`.
- FIFO pointers wrap modulo DEPTH; count is `log2(DEPTH)+1` bits.

## Timing
- Reset values: `rf_we=0`, `rf_rd_addr=0`, `rf_wdata=0`, FIFO empty, counter 0.
  - Outputs after reset: `async_ready=1`, `pipe_stall=0`, `pending_mask=0`.
- `async_ready` and `pipe_stall` are decoded from registered state plus `alu_valid`; no combinational path from `async_valid`.
- Latency:
  - Pipeline request to `rf_we`: 1 cycle.
  - Async accept to `rf_we`: ≥2 cycles (enqueue edge, then dequeue edge) when the pipeline is idle.
- Regfile write completes at the edge after `rf_we`. `pending_mask` for that rd clears on that same edge unless re-queued.
- Reset mid-operation: FIFO contents and the output stage are dropped; no write is issued after `rst_n` deasserts.
- Throughput: one register-file write per cycle maximum.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN`.
  - Register-index width `REG_AW = 5`.
  - Struct `wb_req_t {rd, data}`.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`:
  - Registered storage, `push/pop/full/empty/count`.
  - Exposes per-entry valid and rd for the mask OR.
- Arbiter, starvation counter and output stage live in `wb_arbiter`.

## Test plan
- Reset, then pipeline write (x5, 0xDEADBEEF) → next cycle `rf_we=1`, `rf_rd_addr=5`, `rf_wdata=0xDEADBEEF`; `pending_mask=0x20` for exactly that cycle.
- Pipeline idle, async (x7, 0x1234) accepted → `pending_mask[7]=1` from the following cycle; `rf_we` for x7 two cycles after accept; mask clears after the write.
- Fill 4 async entries with the pipeline writing every cycle:
  - `async_ready=0` when count=4; 5th offer holds.
  - After 8 waiting cycles, `pipe_stall=1` for one cycle and the FIFO head is written.
  - Pipeline data is written the cycle after release.
- Async and pipeline offers with rd=0 → no `rf_we`, FIFO count unchanged, mask stays 0.
- Assert `rst_n` low with 3 entries queued and `rf_we=1` → outputs immediately reach reset values; after release no queued write appears.
- Wrap test: 20 back-to-back async accepts/drains (DEPTH=4) → writes emerge in enqueue order with correct data.
